// File: rtl/lcd_frame_fetch.sv
// lcd_frame_fetch
// Fetches one frame of RGB565 pixels from memory with Avalon-MM burst reads
// into a pixel FIFO. The LCD controller pops the FIFO one pixel per cycle.
//
// Ports:
//   clk, reset             single clock, asynchronous active-high reset
//   vsync                  display VSYNC (active low); its falling edge restarts the frame
//   lcd_read               pop request from the display, one pixel per cycle
//   lcd_readdata[15:0]     registered pixel (0 on underflow or on the vsync edge)
//   underflow              sticky; a pop hit an empty FIFO
//   avm_address[31:0]      byte address of the current burst
//   avm_read               burst request
//   avm_burstcount[7:0]    beats in the current burst
//   avm_waitrequest        slave stall
//   avm_readdata[15:0]     returned pixel
//   avm_readdatavalid      returned pixel is valid
//   o_dbg_state[2:0]       FSM state: IDLE=0 REQ=1 RECV=2 FLUSH=3 DONE=4
//   o_dbg_fill             FIFO fill count, 0..FIFO_DEPTH
//
// Handshake: a request is accepted on a clock edge where avm_read is high and
// avm_waitrequest is low; until then address and burstcount stay stable. Each
// edge with avm_readdatavalid high delivers one beat. Only one burst is ever
// outstanding, so the beat counter always belongs to the burst in flight.
module lcd_frame_fetch #(
  parameter logic [31:0] FB_BASE     = 32'h0000_0000,
  parameter int          FRAME_WORDS = 307200,
  parameter int          BURST_LEN   = 32,
  parameter int          FIFO_DEPTH  = 128
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          vsync,
  input  logic                          lcd_read,
  output logic [15:0]                   lcd_readdata,
  output logic [31:0]                   avm_address,
  output logic                          avm_read,
  output logic [7:0]                    avm_burstcount,
  input  logic                          avm_waitrequest,
  input  logic [15:0]                   avm_readdata,
  input  logic                          avm_readdatavalid,
  output logic                          underflow,
  output logic [2:0]                    o_dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]   o_dbg_fill
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [31:0] FRAME_C = 32'(FRAME_WORDS);
  localparam logic [31:0] BURST_C = 32'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RECV  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        r_state, w_next;
  logic          r_vsync_q;
  logic [31:0]   r_next_addr;
  logic [31:0]   r_remaining;
  logic [31:0]   r_address;
  logic [7:0]    r_burstcount;
  logic [7:0]    r_beat_cnt;
  logic          r_flush_pend;
  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic [15:0]   r_lcd_data;
  logic          r_underflow;

  logic          w_vs_fall;
  logic [7:0]    w_want;
  logic [AW:0]   w_free;
  logic          w_fits;
  logic          w_last_beat;
  logic          w_push;
  logic          w_pop;

  assign w_vs_fall   = r_vsync_q & ~vsync;
  assign w_want      = (r_remaining < BURST_C) ? r_remaining[7:0] : BURST_C[7:0];
  assign w_free      = DEPTH_C - r_count;
  assign w_fits      = (32'(w_free) >= 32'(w_want));
  assign w_last_beat = avm_readdatavalid && (r_beat_cnt == (r_burstcount - 8'd1));

  // The vsync edge empties the FIFO, so neither a push nor a pop may land on it.
  assign w_push = avm_readdatavalid && (r_state != S_FLUSH) && !w_vs_fall && (r_count != DEPTH_C);
  assign w_pop  = lcd_read && (r_count != '0) && !w_vs_fall;

  assign avm_address    = r_address;
  assign avm_burstcount = r_burstcount;
  assign lcd_readdata   = r_lcd_data;
  assign underflow      = r_underflow;
  assign o_dbg_state    = r_state;
  assign o_dbg_fill     = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    avm_read = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_vs_fall && (r_remaining != 32'd0) && w_fits) w_next = S_REQ;
      end
      S_REQ: begin
        avm_read = 1'b1;
        // A vsync seen while stalled is remembered; the burst is then drained and dropped.
        if (!avm_waitrequest) w_next = (w_vs_fall || r_flush_pend) ? S_FLUSH : S_RECV;
      end
      S_RECV: begin
        if (w_last_beat)
          w_next = (!w_vs_fall && (r_remaining == 32'(r_burstcount))) ? S_DONE : S_IDLE;
        else if (w_vs_fall)
          w_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (w_last_beat) w_next = S_IDLE;
      end
      S_DONE: begin
        if (w_vs_fall) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vsync_q    <= 1'b1;
      r_next_addr  <= FB_BASE;
      r_remaining  <= FRAME_C;
      r_address    <= FB_BASE;
      r_burstcount <= 8'd0;
      r_beat_cnt   <= 8'd0;
      r_flush_pend <= 1'b0;
    end else begin
      r_vsync_q <= vsync;
      if (w_vs_fall) begin
        r_next_addr <= FB_BASE;
        r_remaining <= FRAME_C;
      end else if ((r_state == S_RECV) && w_last_beat) begin
        r_next_addr <= r_next_addr + {23'd0, r_burstcount, 1'b0};
        r_remaining <= r_remaining - 32'(r_burstcount);
      end
      if ((r_state == S_IDLE) && (w_next == S_REQ)) begin
        r_address    <= r_next_addr;
        r_burstcount <= w_want;
      end
      if (r_state == S_REQ)
        r_beat_cnt <= 8'd0;
      else if (((r_state == S_RECV) || (r_state == S_FLUSH)) && avm_readdatavalid)
        r_beat_cnt <= r_beat_cnt + 8'd1;
      r_flush_pend <= (r_state == S_REQ) && avm_waitrequest && (r_flush_pend || w_vs_fall);
    end
  end

  // Pixel storage is not reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= avm_readdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_lcd_data  <= 16'h0000;
      r_underflow <= 1'b0;
    end else begin
      if (w_vs_fall) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
      if (lcd_read) begin
        if (w_vs_fall) begin
          r_lcd_data <= 16'h0000;
        end else if (r_count == '0) begin
          r_lcd_data  <= 16'h0000;
          r_underflow <= 1'b1;
        end else begin
          r_lcd_data <= r_mem[r_rd_ptr];
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_frame_fetch.sv
module tb_lcd_frame_fetch;
  localparam logic [31:0] FB_BASE = 32'hFFFF_FF00;  // frame wraps past 2^32
  localparam int FRAME_WORDS = 292;                  // 9 full bursts + a 4-beat tail
  localparam int BURST_LEN   = 32;
  localparam int FIFO_DEPTH  = 128;

  logic        clk, reset, vsync, lcd_read;
  logic [15:0] lcd_readdata;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [7:0]  avm_burstcount;
  logic        avm_waitrequest;
  logic [15:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        underflow;
  logic [2:0]  dbg_state;
  logic [7:0]  dbg_fill;

  lcd_frame_fetch #(
    .FB_BASE(FB_BASE), .FRAME_WORDS(FRAME_WORDS),
    .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .lcd_read(lcd_read),
    .lcd_readdata(lcd_readdata), .avm_address(avm_address), .avm_read(avm_read),
    .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .underflow(underflow), .o_dbg_state(dbg_state), .o_dbg_fill(dbg_fill)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame buffer content: word index ramp derived from the byte address.
  function automatic logic [15:0] pix(input logic [31:0] a);
    return a[16:1];
  endfunction

  logic [15:0] exp_q[$];    // expected pixels, frame order
  logic [31:0] beat_q[$];   // addresses the slave still has to return
  int  avail = 0, discard = 0, popped_frame = 0, n_bursts = 0, bursts_since_vs = 0;
  int  cur_sent = 0, lat = 0, stall_left = 0, run = 0, max_run = 0;
  logic [31:0] m_addr, m_rem;
  logic        uf_m;
  logic [15:0] last_pix;
  logic        tb_vs_q;
  bit          disp_en = 0, force_read = 0, rand_wait = 0;

  // ---------------- slave driver ----------------
  initial begin
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 16'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        beat_q.delete(); lat = 0; cur_sent = 0;
        avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
      end else begin
        if (lat > 0) lat--;
        if (beat_q.size() > 0 && lat == 0 && $urandom_range(0, 7) != 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = pix(beat_q.pop_front());
          cur_sent++;
        end else begin
          avm_readdatavalid = 1'b0;
          avm_readdata = 16'($urandom);
        end
        if (stall_left > 0 && avm_read) begin
          avm_waitrequest = 1'b1;
          stall_left--;
        end else begin
          avm_waitrequest = rand_wait ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        if (avm_read && !avm_waitrequest) begin
          for (int i = 0; i < int'(avm_burstcount); i++) beat_q.push_back(avm_address + 32'(2 * i));
          lat = 3;
          cur_sent = 0;
        end
      end
    end
  end

  // ---------------- display driver ----------------
  initial begin
    lcd_read = 1'b0;
    forever begin
      @(negedge clk);
      if (force_read) lcd_read = 1'b1;
      else lcd_read = disp_en && (avail > 0) && ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic p_read, p_valid, p_wait, p_vs, p_rst, p_fall;
    logic s_read, prev_stall;
    logic [31:0] s_addr, h_addr, exp_bc;
    logic [7:0]  s_bc, h_bc;
    logic [15:0] exp_pix;
    s_read = 0; prev_stall = 0; s_addr = 0; s_bc = 0; h_addr = 0; h_bc = 0;
    forever begin
      @(posedge clk);
      p_read = lcd_read; p_valid = avm_readdatavalid; p_wait = avm_waitrequest;
      p_vs = vsync; p_rst = reset;
      #1;
      if (p_rst) begin
        exp_q.delete(); avail = 0; discard = 0; popped_frame = 0;
        m_addr = FB_BASE; m_rem = 32'(FRAME_WORDS); uf_m = 0; last_pix = 16'h0;
        tb_vs_q = 1'b1; prev_stall = 0; run = 0;
      end else begin
        p_fall = tb_vs_q && !p_vs;
        tb_vs_q = p_vs;
        // request held stable while stalled
        if (prev_stall) begin
          check("stall_read", 32'(s_read), 32'd1);
          check("stall_addr", s_addr, h_addr);
          check("stall_bcount", 32'(s_bc), 32'(h_bc));
        end
        if (s_read && p_wait) run++; else run = 0;
        if (run > max_run) max_run = run;
        prev_stall = s_read && p_wait;
        h_addr = s_addr; h_bc = s_bc;
        // accepted request against the frame model
        if (s_read && !p_wait) begin
          exp_bc = (m_rem < 32'(BURST_LEN)) ? m_rem : 32'(BURST_LEN);
          check("req_in_frame", 32'(m_rem != 0), 32'd1);
          check("req_addr", s_addr, m_addr);
          check("req_bcount", 32'(s_bc), exp_bc);
          for (int i = 0; i < int'(exp_bc); i++) exp_q.push_back(pix(m_addr + 32'(2 * i)));
          m_addr = m_addr + (exp_bc << 1);
          m_rem  = m_rem - exp_bc;
          n_bursts++; bursts_since_vs++;
        end
        // pop
        if (p_read) begin
          if (p_fall) exp_pix = 16'h0;
          else if (avail > 0) begin
            exp_pix = exp_q.pop_front(); avail--; popped_frame++;
          end else begin
            exp_pix = 16'h0; uf_m = 1'b1;
          end
          last_pix = exp_pix;
          check("lcd_pixel", 32'(lcd_readdata), 32'(exp_pix));
        end else begin
          check("lcd_hold", 32'(lcd_readdata), 32'(last_pix));
        end
        // push
        if (p_valid && !p_fall) begin
          if (discard > 0) discard--;
          else avail++;
        end
        if (p_fall) begin
          exp_q.delete(); avail = 0; popped_frame = 0; bursts_since_vs = 0;
          discard = beat_q.size();
          m_addr = FB_BASE; m_rem = 32'(FRAME_WORDS);
          check("vsync_fifo_empty", 32'(dbg_fill), 32'd0);
        end
        check("underflow", 32'(underflow), 32'(uf_m));
      end
      s_read = avm_read; s_addr = avm_address; s_bc = avm_burstcount;
    end
  end

  // ---------------- main sequence ----------------
  task automatic check_reset_values();
    check("rst_avm_read", 32'(avm_read), 32'd0);
    check("rst_avm_address", avm_address, FB_BASE);
    check("rst_burstcount", 32'(avm_burstcount), 32'd0);
    check("rst_lcd_readdata", 32'(lcd_readdata), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_state_idle", 32'(dbg_state), 32'd0);
    check("rst_fifo_empty", 32'(dbg_fill), 32'd0);
  endtask

  initial begin
    int cyc;
    int saved;
    reset = 1'b1; vsync = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_reset_values();
    @(negedge clk); #1 reset = 1'b0;

    // fill with display idle: four 32-beat bursts, then requests stop
    cyc = 0;
    while (avail != FIFO_DEPTH && cyc < 4000) begin @(negedge clk); #1; cyc++; end
    check("fill_reached", 32'(cyc < 4000), 32'd1);
    repeat (40) @(negedge clk);
    #1;
    check("fill_bursts", 32'(n_bursts), 32'd4);
    check("fill_count", 32'(dbg_fill), 32'(FIFO_DEPTH));
    check("fill_no_req", 32'(avm_read), 32'd0);

    // drain the whole frame with random pops and random stalls
    rand_wait = 1; disp_en = 1;
    cyc = 0;
    while (popped_frame != FRAME_WORDS && cyc < 8000) begin @(negedge clk); #1; cyc++; end
    check("frame1_drained", 32'(cyc < 8000), 32'd1);
    repeat (10) @(negedge clk);
    #1;
    check("frame1_done", 32'(dbg_state), 32'd4);
    check("frame1_bursts", 32'(n_bursts), 32'd10);
    saved = n_bursts;
    repeat (50) @(negedge clk);
    #1 check("done_no_req", 32'(n_bursts), 32'(saved));

    // vsync restart; first request stalled 5 cycles; then vsync mid-burst
    stall_left = 5; max_run = 0;
    @(negedge clk); #1 vsync = 1'b0;
    @(negedge clk); #1 vsync = 1'b1;
    cyc = 0;
    while (!(bursts_since_vs >= 2 && cur_sent >= 10 && beat_q.size() > 0) && cyc < 4000) begin
      @(negedge clk); #1; cyc++;
    end
    check("midburst_reached", 32'(cyc < 4000), 32'd1);
    check("stall_run_5", 32'(max_run >= 5), 32'd1);
    vsync = 1'b0;
    @(negedge clk); #1 vsync = 1'b1;
    cyc = 0;
    while (popped_frame != FRAME_WORDS && cyc < 8000) begin @(negedge clk); #1; cyc++; end
    check("frame2_drained", 32'(cyc < 8000), 32'd1);
    repeat (10) @(negedge clk);
    #1 check("frame2_done", 32'(dbg_state), 32'd4);

    // underflow: pops on an empty FIFO
    disp_en = 0;
    repeat (5) @(negedge clk);
    #1 force_read = 1;
    repeat (4) @(negedge clk);
    #1 force_read = 0;
    repeat (20) @(negedge clk);
    #1;
    check("uf_sticky", 32'(underflow), 32'd1);
    check("uf_data_zero", 32'(lcd_readdata), 32'd0);

    // reset clears everything and fetching restarts without vsync
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_reset_values();
    saved = n_bursts;
    reset = 1'b0;
    cyc = 0;
    while (n_bursts == saved && cyc < 200) begin @(negedge clk); #1; cyc++; end
    check("restart_after_reset", 32'(cyc < 200), 32'd1);
    repeat (60) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
